// File: rtl/spi_master_pkg.sv
// Shared types for the SPI master: FSM state encoding, latched transfer mode
// and a counter-width helper that keeps one-count counters at least one bit wide.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } mode_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_divider.sv
// SCLK timing for the SPI master: half-period counter producing a tick every
// CLK_DIV enabled cycles, plus the SCLK edge index and its parity during SHIFT.
module spi_sclk_divider
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned N_EDGES = 32,
  localparam int unsigned CW = cnt_width(CLK_DIV),
  localparam int unsigned EW = cnt_width(N_EDGES)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic          shift_i,
  output logic          tick_o,
  output logic [EW-1:0] edge_idx_o,
  output logic          edge_odd_o,
  output logic          last_edge_o
);

  logic [CW-1:0] cnt_q;
  logic [EW-1:0] edge_q;

  assign tick_o      = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign edge_idx_o  = edge_q;
  assign edge_odd_o  = edge_q[0];
  assign last_edge_o = (edge_q == EW'(N_EDGES - 1));

  // Edge index saturates at the final edge; it is cleared whenever the divider is idle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !en_i) begin
      cnt_q  <= '0;
      edge_q <= '0;
    end else begin
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
      if (tick_o && shift_i && !last_edge_o) begin
        edge_q <= edge_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master with runtime CPOL/CPHA/bit order and valid/ready intake.
// Define SPI_MASTER_RX_EN to build the MISO capture path; otherwise rx outputs tie to zero.
module spi_master_gen
  import spi_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYC    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic                  i_lsb_first,
  input  logic                  i_miso,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_cs_n,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid
);

  localparam int unsigned N_EDGES  = 2 * DATA_WIDTH;
  localparam int unsigned EW       = cnt_width(N_EDGES);
  localparam int unsigned GW       = cnt_width(GAP_CYC);
  localparam int unsigned GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  state_e                state_q;
  mode_t                 mode_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [GW-1:0]         gap_q;
  logic                  sclk_q, mosi_q, cs_n_q, ready_q, done_q;

  logic          tick, edge_odd, last_edge;
  logic [EW-1:0] edge_idx;
  logic          div_en, in_shift, accept, advance_now, next_bit;

  assign div_en   = (state_q == ST_LEAD) || (state_q == ST_SHIFT) || (state_q == ST_TRAIL);
  assign in_shift = (state_q == ST_SHIFT);
  assign accept   = i_valid && ready_q;
  assign next_bit = mode_q.lsb_first ? shreg_q[0] : shreg_q[DATA_WIDTH-1];

  spi_sclk_divider #(
    .CLK_DIV (CLK_DIV),
    .N_EDGES (N_EDGES)
  ) u_div (
    .clk_i       (i_clk),
    .rst_n_i     (i_rst_n),
    .en_i        (div_en),
    .shift_i     (in_shift),
    .tick_o      (tick),
    .edge_idx_o  (edge_idx),
    .edge_odd_o  (edge_odd),
    .last_edge_o (last_edge)
  );

  // The first bit is presented at accept, so CPHA=1 skips the advance on edge 0.
  always_comb begin
    advance_now = 1'b0;
    if (in_shift && tick) begin
      advance_now = mode_q.cpha ? (!edge_odd && (edge_idx != '0))
                                : (edge_odd && !last_edge);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      shreg_q <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          sclk_q  <= mode_q.cpol;
          ready_q <= 1'b1;
          if (accept) begin
            mode_q.cpol      <= i_cpol;
            mode_q.cpha      <= i_cpha;
            mode_q.lsb_first <= i_lsb_first;
            sclk_q  <= i_cpol;
            cs_n_q  <= 1'b0;
            ready_q <= 1'b0;
            mosi_q  <= i_lsb_first ? i_data[0] : i_data[DATA_WIDTH-1];
            shreg_q <= i_lsb_first ? (i_data >> 1) : (i_data << 1);
            state_q <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (tick) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            if (advance_now) begin
              mosi_q  <= next_bit;
              shreg_q <= mode_q.lsb_first ? (shreg_q >> 1) : (shreg_q << 1);
            end
            if (last_edge) state_q <= ST_TRAIL;
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
            done_q <= 1'b1;
            if (GAP_CYC == 0) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_GAP;
              gap_q   <= GW'(GAP_LOAD);
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_sclk  = sclk_q;
  assign o_mosi  = mosi_q;
  assign o_cs_n  = cs_n_q;
  assign o_done  = done_q;

`ifdef SPI_MASTER_RX_EN
  logic [DATA_WIDTH-1:0] rx_q, rx_data_q;
  logic                  rx_valid_q, sample_now;

  assign sample_now = in_shift && tick && (mode_q.cpha ? edge_odd : !edge_odd);

  // W samples per frame fill rx_q completely, so it needs no clear at accept.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (sample_now) begin
        rx_q <= mode_q.lsb_first ? {i_miso, rx_q[DATA_WIDTH-1:1]}
                                 : {rx_q[DATA_WIDTH-2:0], i_miso};
      end
      if ((state_q == ST_TRAIL) && tick) begin
        rx_data_q  <= rx_q;
        rx_valid_q <= 1'b1;
      end
    end
  end

  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
`else
  logic unused_miso;
  assign unused_miso = i_miso;
  assign o_rx_data   = '0;
  assign o_rx_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_gen.sv
// Self-checking bench for spi_master_gen: two instances (CLK_DIV=2/GAP=2 and CLK_DIV=1/GAP=0)
// with MISO looped to MOSI, checked against a frame-level model of the serial protocol.
module tb_spi_master_gen;

  localparam int W = 16;

`ifdef SPI_MASTER_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, valid0, valid1, cpol, cpha, lsb;
  logic [W-1:0] data;
  logic         ready0, sclk0, mosi0, cs0, done0, rxv0;
  logic         ready1, sclk1, mosi1, cs1, done1, rxv1;
  logic [W-1:0] rxd0, rxd1;

  spi_master_gen #(.DATA_WIDTH(W), .CLK_DIV(2), .GAP_CYC(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid0), .o_ready(ready0), .i_data(data),
    .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb), .i_miso(mosi0),
    .o_sclk(sclk0), .o_mosi(mosi0), .o_cs_n(cs0), .o_done(done0),
    .o_rx_data(rxd0), .o_rx_valid(rxv0)
  );

  spi_master_gen #(.DATA_WIDTH(W), .CLK_DIV(1), .GAP_CYC(0)) dut_div1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid1), .o_ready(ready1), .i_data(data),
    .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb), .i_miso(mosi1),
    .o_sclk(sclk1), .o_mosi(mosi1), .o_cs_n(cs1), .o_done(done1),
    .o_rx_data(rxd1), .o_rx_valid(rxv1)
  );

  // Monitored instance selected by sel.
  int           sel = 0;
  logic         m_ready, m_sclk, m_mosi, m_cs, m_done, m_rxv;
  logic [W-1:0] m_rxd;
  assign m_ready = (sel == 1) ? ready1 : ready0;
  assign m_sclk  = (sel == 1) ? sclk1  : sclk0;
  assign m_mosi  = (sel == 1) ? mosi1  : mosi0;
  assign m_cs    = (sel == 1) ? cs1    : cs0;
  assign m_done  = (sel == 1) ? done1  : done0;
  assign m_rxv   = (sel == 1) ? rxv1   : rxv0;
  assign m_rxd   = (sel == 1) ? rxd1   : rxd0;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] last_rx [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int s);
    return (s == 1) ? 1 : 2;
  endfunction

  function automatic int gap_of(input int s);
    return (s == 1) ? 0 : 2;
  endfunction

  // Called at a negedge; returns at the negedge of the first cs-low cycle.
  task automatic do_accept(input logic [W-1:0] d, input logic pol, input logic pha,
                           input logic lsbf, input string tag);
    int n = 0;
    data = d; cpol = pol; cpha = pha; lsb = lsbf;
    if (sel == 1) valid1 = 1'b1; else valid0 = 1'b1;
    while (!m_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "/ready_wait"}, 32'(m_ready), 32'd1);
    @(negedge clk);
  endtask

  // Observes one frame as a receiver would, from the first cs-low cycle to the first cs-high cycle.
  task automatic monitor_frame(input logic [W-1:0] d, input logic pol, input logic pha,
                               input logic lsbf, input string tag);
    int           div = div_of(sel);
    int           low = 0, tog = 0, bad_sp = 0, since = 0, nbits = 0, early_done = 0;
    logic         prev = pol;
    logic [W-1:0] got = '0;
    logic [W-1:0] exp_rx;
    check_eq({tag, "/rx_hold"}, 32'(m_rxd), 32'(last_rx[sel]));
    while (m_cs == 1'b0 && low < 400) begin
      low++;
      if (m_done) early_done++;
      if (m_sclk !== prev) begin
        if (tog > 0 && since != div) bad_sp++;
        if (pha ? (tog % 2 == 1) : (tog % 2 == 0)) begin
          if (nbits < W) got[lsbf ? nbits : W - 1 - nbits] = m_mosi;
          nbits++;
        end
        tog++;
        since = 0;
        prev  = m_sclk;
      end
      since++;
      @(negedge clk);
    end
    exp_rx = RX_EN ? d : '0;
    check_eq({tag, "/cs_low_cycles"}, 32'(low), 32'((2 * W + 2) * div));
    check_eq({tag, "/sclk_toggles"}, 32'(tog), 32'(2 * W));
    check_eq({tag, "/sclk_spacing"}, 32'(bad_sp), 32'd0);
    check_eq({tag, "/mosi_word"}, 32'(got), 32'(d));
    check_eq({tag, "/done_early"}, 32'(early_done), 32'd0);
    check_eq({tag, "/sclk_idle"}, 32'(m_sclk), 32'(pol));
    check_eq({tag, "/gap_mosi"}, 32'(m_mosi), 32'd0);
    check_eq({tag, "/done"}, 32'(m_done), 32'd1);
    check_eq({tag, "/ready_gap"}, 32'(m_ready), 32'(gap_of(sel) == 0));
    check_eq({tag, "/rx_valid"}, 32'(m_rxv), 32'(RX_EN));
    check_eq({tag, "/rx_data"}, 32'(m_rxd), 32'(exp_rx));
    last_rx[sel] = exp_rx;
  endtask

  // Single frame with mid-frame scrambling of every latched input.
  task automatic send(input logic [W-1:0] d, input logic pol, input logic pha,
                      input logic lsbf, input string tag);
    do_accept(d, pol, pha, lsbf, tag);
    valid0 = 1'b0; valid1 = 1'b0;
    data = W'($urandom); cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
    monitor_frame(d, pol, pha, lsbf, tag);
    @(negedge clk);
    check_eq({tag, "/pulse_width"}, 32'({m_done, m_rxv}), 32'd0);
  endtask

  // Back-to-back frames with i_valid held; measures the cs-high gap between them.
  task automatic send_pair(input logic [W-1:0] d1, input logic [W-1:0] d2, input logic pol,
                           input logic pha, input logic lsbf, input string tag);
    int hi = 0;
    do_accept(d1, pol, pha, lsbf, {tag, "a"});
    data = W'($urandom);
    monitor_frame(d1, pol, pha, lsbf, {tag, "a"});
    data = d2;
    while (m_cs == 1'b1 && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    check_eq({tag, "/cs_high_gap"}, 32'(hi), 32'(gap_of(sel) + 1));
    valid0 = 1'b0; valid1 = 1'b0;
    data = W'($urandom);
    monitor_frame(d2, pol, pha, lsbf, {tag, "b"});
    @(negedge clk);
  endtask

  initial begin
    int tog;
    int n;
    logic prev;
    last_rx[0] = '0;
    last_rx[1] = '0;
    rst_n = 1'b0; valid0 = 1'b1; valid1 = 1'b1;
    data = '0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;

    // Reset held with i_valid asserted.
    repeat (4) begin
      @(negedge clk);
      check_eq("rst/outs", 32'({cs0, sclk0, mosi0, ready0, done0, rxv0}), 32'b100000);
      check_eq("rst/rx_data", 32'(rxd0), 32'd0);
      check_eq("rst/ready1", 32'(ready1), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst/ready_after", 32'(ready0), 32'd1);
    check_eq("rst/ready1_after", 32'(ready1), 32'd1);
    valid0 = 1'b0; valid1 = 1'b0;
    @(negedge clk);

    sel = 0;
    send(16'hA5A3, 1'b0, 1'b0, 1'b1, "mode0_lsb");
    send(16'h8001, 1'b1, 1'b1, 1'b0, "mode3_msb");
    send_pair(16'h1234, 16'hFFFF, 1'b0, 1'b0, 1'b1, "held");

    // Reset after SCLK edge 10.
    do_accept(16'h3C5A, 1'b0, 1'b0, 1'b1, "abort");
    valid0 = 1'b0;
    tog = 0; n = 0; prev = m_sclk;
    while (tog < 11 && n < 300) begin
      @(negedge clk);
      n++;
      if (m_sclk !== prev) begin
        tog++;
        prev = m_sclk;
      end
    end
    check_eq("abort/edges_seen", 32'(tog), 32'd11);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("abort/outs", 32'({cs0, sclk0, mosi0, ready0, done0, rxv0}), 32'b100000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort/no_done", 32'(done0), 32'd0);
    check_eq("abort/ready", 32'(ready0), 32'd1);
    last_rx[0] = '0;
    last_rx[1] = '0;
    send(16'h0F0F, 1'b0, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 8; i++) begin
      send(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rand_div2");
    end

    sel = 1;
    send(16'hFFFF, 1'b0, 1'b1, 1'b1, "div1_mode1");
    for (int i = 0; i < 4; i++) begin
      send(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rand_div1");
    end
    send_pair(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "held_div1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
